qspi_read_arbiter: RTL and testbench

Shares the single-lane SPI path to the boot/XIP flash between two 32-bit read requesters, such as the instruction and data buses. Each accepted request becomes one standard READ (0x03) transaction: 8-bit command, 24-bit address, 32 data bits. The returned word is handed back to the requester that issued it. The block sits between the CPU/DMA bus fabric and the chip's `qspi_*` pads. It drives all four chip selects and holds WP#/HOLD# inactive.

---
 rtl/qspi_read_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_qspi_read_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_read_arbiter.sv
// qspi_read_arbiter
// Shares one single-lane SPI flash path between two 32-bit read requesters.
// Each accepted request becomes one READ (0x03) transaction: 8-bit command,
// 24-bit address, then 32 data bits clocked in. The word is returned byte-swapped
// so that the byte at the requested address lands in rdata[7:0].
//
// Ports:
//   clk, reset            : single clock, synchronous active-high reset
//   m0_valid/m0_addr      : requester 0 request ([25:24] chip select, [23:0] byte address)
//   m0_ready/m0_rdata     : requester 0 one-cycle completion pulse and read word
//   m1_*                  : same for requester 1
//   qspi_sck              : SPI clock, mode 0 (idles low)
//   qspi_cs_n[3:0]        : active-low chip selects, at most one low
//   qspi_mosi / qspi_miso : serial data out (dq0) / in (dq1)
//   qspi_wp_n, qspi_hold_n: held inactive (high)
//
// Parameters:
//   DIV      : SCK half-period in clk cycles (1..15)
//   DESELECT : minimum CS-high clk cycles between transactions (1..15)

module qspi_read_arbiter #(
  parameter int DIV      = 1,
  parameter int DESELECT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [25:0] m0_addr,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [25:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        qspi_sck,
  output logic [3:0]  qspi_cs_n,
  output logic        qspi_mosi,
  input  logic        qspi_miso,
  output logic        qspi_wp_n,
  output logic        qspi_hold_n
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(DESELECT - 1);

  state_t      state_reg, state_next;
  logic [63:0] shift_reg, shift_next;
  logic [31:0] rx_reg, rx_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;
  logic [3:0]  div_cnt_reg, div_cnt_next;
  logic [5:0]  bit_cnt_reg, bit_cnt_next;
  logic [3:0]  gap_cnt_reg, gap_cnt_next;
  logic        sck_reg, sck_next;
  logic [3:0]  cs_n_reg, cs_n_next;
  logic        m0_ready_reg, m0_ready_next;
  logic        m1_ready_reg, m1_ready_next;
  logic [31:0] m0_rdata_reg, m0_rdata_next;
  logic [31:0] m1_rdata_reg, m1_rdata_next;

  logic        grant;
  logic [25:0] grant_addr;
  logic [31:0] rx_swapped;

  // First received byte (the one at addr) sits in rx[31:24]; move it to [7:0].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_swap
      assign rx_swapped[8*gi +: 8] = rx_reg[8*(3-gi) +: 8];
    end
  endgenerate

  // Round-robin: on a tie the port that did not win last time is granted.
  assign grant      = (m0_valid && m1_valid) ? ~last_reg : m1_valid;
  assign grant_addr = grant ? m1_addr : m0_addr;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    rx_next       = rx_reg;
    owner_next    = owner_reg;
    last_next     = last_reg;
    div_cnt_next  = div_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    sck_next      = sck_reg;
    cs_n_next     = cs_n_reg;
    m0_ready_next = 1'b0;
    m1_ready_next = 1'b0;
    m0_rdata_next = m0_rdata_reg;
    m1_rdata_next = m1_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          shift_next   = {8'h03, grant_addr[23:0], 32'h0};
          cs_n_next    = ~(4'b0001 << grant_addr[25:24]);
          owner_next   = grant;
          last_next    = grant;
          div_cnt_next = 4'd0;
          bit_cnt_next = 6'd0;
          rx_next      = 32'h0;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = 4'd0;
          if (!sck_reg) begin
            sck_next = 1'b1;
            rx_next  = {rx_reg[30:0], qspi_miso};
          end else begin
            // Falling SCK: advance MOSI. After the 64th bit the register is all
            // zero, so MOSI idles low without a separate output register.
            sck_next   = 1'b0;
            shift_next = {shift_reg[62:0], 1'b0};
            if (bit_cnt_reg == 6'd63) begin
              cs_n_next    = 4'hF;
              gap_cnt_next = 4'd0;
              state_next   = DONE;
              if (owner_reg) begin
                m1_ready_next = 1'b1;
                m1_rdata_next = rx_swapped;
              end else begin
                m0_ready_next = 1'b1;
                m0_rdata_next = rx_swapped;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 6'd1;
            end
          end
        end else begin
          div_cnt_next = div_cnt_reg + 4'd1;
        end
      end
      DONE: begin
        state_next = GAP;
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cs_n_next  = 4'hF;
        sck_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= 64'h0;
      rx_reg       <= 32'h0;
      owner_reg    <= 1'b0;
      last_reg     <= 1'b1;
      div_cnt_reg  <= 4'd0;
      bit_cnt_reg  <= 6'd0;
      gap_cnt_reg  <= 4'd0;
      sck_reg      <= 1'b0;
      cs_n_reg     <= 4'hF;
      m0_ready_reg <= 1'b0;
      m1_ready_reg <= 1'b0;
      m0_rdata_reg <= 32'h0;
      m1_rdata_reg <= 32'h0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      rx_reg       <= rx_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      sck_reg      <= sck_next;
      cs_n_reg     <= cs_n_next;
      m0_ready_reg <= m0_ready_next;
      m1_ready_reg <= m1_ready_next;
      m0_rdata_reg <= m0_rdata_next;
      m1_rdata_reg <= m1_rdata_next;
    end
  end

  assign m0_ready    = m0_ready_reg;
  assign m1_ready    = m1_ready_reg;
  assign m0_rdata    = m0_rdata_reg;
  assign m1_rdata    = m1_rdata_reg;
  assign qspi_sck    = sck_reg;
  assign qspi_cs_n   = cs_n_reg;
  assign qspi_mosi   = shift_reg[63];
  assign qspi_wp_n   = 1'b1;
  assign qspi_hold_n = 1'b1;

endmodule

// File: tb/tb_qspi_read_arbiter.sv
// Testbench for qspi_read_arbiter: two instances (DIV=1/DESELECT=4 and
// DIV=3/DESELECT=2), a behavioural SPI flash per instance, and a scoreboard
// of expected completions (port, word, ready cycle, wire-level observations).

module tb_qspi_read_arbiter;

  localparam int DIV_A = 1;
  localparam int DES_A = 4;
  localparam int DIV_B = 3;
  localparam int DES_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v0[2] = '{1'b0, 1'b0};
  logic        v1[2] = '{1'b0, 1'b0};
  logic [25:0] a0[2] = '{26'h0, 26'h0};
  logic [25:0] a1[2] = '{26'h0, 26'h0};
  logic        r0[2], r1[2];
  logic [31:0] d0[2], d1[2];
  logic        sck[2], mosi[2], wp[2], hold[2];
  logic        miso[2] = '{1'b0, 1'b0};
  logic [3:0]  csn[2];

  qspi_read_arbiter #(.DIV(DIV_A), .DESELECT(DES_A)) dut_a (
    .clk(clk), .reset(rst),
    .m0_valid(v0[0]), .m0_addr(a0[0]), .m0_ready(r0[0]), .m0_rdata(d0[0]),
    .m1_valid(v1[0]), .m1_addr(a1[0]), .m1_ready(r1[0]), .m1_rdata(d1[0]),
    .qspi_sck(sck[0]), .qspi_cs_n(csn[0]), .qspi_mosi(mosi[0]), .qspi_miso(miso[0]),
    .qspi_wp_n(wp[0]), .qspi_hold_n(hold[0])
  );

  qspi_read_arbiter #(.DIV(DIV_B), .DESELECT(DES_B)) dut_b (
    .clk(clk), .reset(rst),
    .m0_valid(v0[1]), .m0_addr(a0[1]), .m0_ready(r0[1]), .m0_rdata(d0[1]),
    .m1_valid(v1[1]), .m1_addr(a1[1]), .m1_ready(r1[1]), .m1_rdata(d1[1]),
    .qspi_sck(sck[1]), .qspi_cs_n(csn[1]), .qspi_mosi(mosi[1]), .qspi_miso(miso[1]),
    .qspi_wp_n(wp[1]), .qspi_hold_n(hold[1])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic int des_of(input int i);
    return (i == 0) ? DES_A : DES_B;
  endfunction

  // Flash contents: address 0x10..0x13 on cs0 reads 11 22 33 44.
  function automatic logic [7:0] flash_byte(input logic [1:0] cs, input logic [23:0] a);
    logic [3:0] nib;
    nib = a[3:0] + 4'd1;
    return {nib, nib} ^ a[23:16] ^ {cs, 6'b0};
  endfunction

  function automatic logic [31:0] exp_word(input logic [25:0] ad);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = flash_byte(ad[25:24], ad[23:0] + 24'(k));
    return w;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] m);
    case (m)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // ---------------- flash model (one per instance) ----------------
  // fl_bad bits: 0 SCK phase length, 1 CS changed mid-transaction,
  // 2 MOSI high in data phase, 3 CS-high gap too short, 4 SCK high with CS high
  int          fl_cnt[2], fl_low[2], fl_run[2], fl_hi[2], fl_txn[2];
  logic [31:0] fl_sh[2];
  logic [3:0]  fl_mask[2];
  logic        fl_prev_sck[2], fl_prev_high[2], fl_first[2];
  logic [7:0]  fl_bad[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        fl_cnt[i] = 0; fl_low[i] = 0; fl_run[i] = 0; fl_hi[i] = 0; fl_txn[i] = 0;
        fl_sh[i] = 32'h0; fl_mask[i] = 4'hF; fl_prev_sck[i] = 1'b0;
        fl_prev_high[i] = 1'b1; fl_first[i] = 1'b0; fl_bad[i] = 8'h0; miso[i] = 1'b0;
      end else if (csn[i] == 4'hF) begin
        if (sck[i]) fl_bad[i][4] = 1'b1;
        fl_hi[i]++;
        fl_prev_high[i] = 1'b1;
        miso[i] = 1'b0;
      end else begin
        if (fl_prev_high[i]) begin
          fl_bad[i] = {3'b0, fl_bad[i][4], 4'b0};
          if (fl_txn[i] > 0 && fl_hi[i] < des_of(i) + 1) fl_bad[i][3] = 1'b1;
          fl_txn[i]++;
          fl_cnt[i] = 0; fl_sh[i] = 32'h0; fl_low[i] = 0; fl_run[i] = 0;
          fl_first[i] = 1'b1; fl_mask[i] = csn[i]; fl_prev_sck[i] = 1'b0;
          fl_hi[i] = 0; fl_prev_high[i] = 1'b0;
        end
        fl_low[i]++;
        if (csn[i] != fl_mask[i]) fl_bad[i][1] = 1'b1;
        if (sck[i] != fl_prev_sck[i]) begin
          if (fl_run[i] != (fl_first[i] ? div_of(i) + 1 : div_of(i))) fl_bad[i][0] = 1'b1;
          fl_run[i] = 1;
          fl_first[i] = 1'b0;
          if (sck[i]) begin
            if (fl_cnt[i] < 32) fl_sh[i] = {fl_sh[i][30:0], mosi[i]};
            else if (mosi[i]) fl_bad[i][2] = 1'b1;
            fl_cnt[i]++;
          end else if (fl_cnt[i] >= 32 && fl_cnt[i] < 64) begin
            int         j;
            logic [7:0] b;
            j = fl_cnt[i] - 32;
            b = flash_byte(idx_of(fl_mask[i]), fl_sh[i][23:0] + 24'(j / 8));
            miso[i] = b[7 - (j % 8)];
          end
        end else begin
          fl_run[i]++;
        end
        fl_prev_sck[i] = sck[i];
      end
    end
  end

  // ---------------- checking and scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int          inst;
    logic        port;
    logic [25:0] addr;
    logic [31:0] data;
    int          rdy;
  } sb_t;

  sb_t         sbq[$];
  int          free_at[2] = '{0, 0};
  logic        exp_last[2] = '{1'b1, 1'b1};
  logic [31:0] last_d[2][2];

  task automatic monitor();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic        rv;
        logic [31:0] data, other;
        logic [3:0]  m;
        sb_t         e;
        rv    = (p == 0) ? r0[i] : r1[i];
        data  = (p == 0) ? d0[i] : d1[i];
        other = (p == 0) ? d1[i] : d0[i];
        if (rst) last_d[i][p] = 32'h0;
        else if (rv) begin
          chk("ready_expected", 64'(sbq.size() > 0), 64'(1));
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            m = 4'hF;
            m[e.addr[25:24]] = 1'b0;
            $display("txn inst=%0d port=%0d addr=%07h rdata=%08h cycle=%0d", i, p, e.addr, data, cyc);
            chk("inst", 64'(i), 64'(e.inst));
            chk("port", 64'(p), 64'(e.port));
            chk("rdata", 64'(data), 64'(e.data));
            chk("ready_cycle", 64'(cyc), 64'(e.rdy));
            chk("cmd_addr", 64'(fl_sh[i]), 64'({8'h03, e.addr[23:0]}));
            chk("cs_n", 64'(fl_mask[i]), 64'(m));
            chk("sck_rises", 64'(fl_cnt[i]), 64'(64));
            chk("cs_low_cycles", 64'(fl_low[i]), 64'(1 + 128 * div_of(i)));
            chk("pin_flags", 64'(fl_bad[i]), 64'(0));
            chk("other_rdata", 64'(other), 64'(last_d[i][1-p]));
            chk("wp_hold", 64'({wp[i], hold[i]}), 64'(2'b11));
            last_d[i][p] = e.data;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic push_one(input int inst, input logic port, input logic [25:0] ad, input int t0);
    sb_t e;
    int  g;
    g = (t0 > free_at[inst]) ? t0 : free_at[inst];
    e.inst = inst;
    e.port = port;
    e.addr = ad;
    e.data = exp_word(ad);
    e.rdy  = g + 2 + 128 * div_of(inst);
    free_at[inst]  = e.rdy + 1 + des_of(inst);
    exp_last[inst] = port;
    sbq.push_back(e);
  endtask

  // Called at a falling edge; raises the requested valids and runs until all
  // requested ports have seen ready (or the cycle budget runs out).
  task automatic run_req(input int inst, input logic [1:0] ports, input logic [25:0] ad0,
                         input logic [25:0] ad1, input int drop_at);
    logic [1:0] pend;
    logic       first;
    int         t0;
    t0 = cyc;
    if (ports[0]) a0[inst] = ad0;
    if (ports[1]) a1[inst] = ad1;
    v0[inst] = ports[0];
    v1[inst] = ports[1];
    first = (ports == 2'b11) ? ~exp_last[inst] : ports[1];
    push_one(inst, first, first ? ad1 : ad0, t0);
    if (ports == 2'b11) push_one(inst, ~first, first ? ad0 : ad1, t0);
    pend = ports;
    for (int n = 0; n < 3000 && pend != 2'b00; n++) begin
      tick();
      if (drop_at > 0 && cyc == t0 + drop_at) v0[inst] = 1'b0;
      if (r0[inst]) begin v0[inst] = 1'b0; pend[0] = 1'b0; end
      if (r1[inst]) begin v1[inst] = 1'b0; pend[1] = 1'b0; end
    end
    chk("req_timeout", 64'(pend), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int txn_before;

    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs_n", 64'(csn[i]), 64'(4'hF));
      chk("rst_sck", 64'(sck[i]), 64'(0));
      chk("rst_mosi", 64'(mosi[i]), 64'(0));
      chk("rst_m0_ready", 64'(r0[i]), 64'(0));
      chk("rst_m1_ready", 64'(r1[i]), 64'(0));
      chk("rst_m0_rdata", 64'(d0[i]), 64'(0));
      chk("rst_m1_rdata", 64'(d1[i]), 64'(0));
      chk("rst_wp_hold", 64'({wp[i], hold[i]}), 64'(2'b11));
    end
    rst = 1'b0;

    // Simultaneous requests straight after reset: m0 first, then m1.
    run_req(0, 2'b11, 26'h0000100, 26'h0000204, 0);

    // Single read of 11 22 33 44.
    repeat (8) tick();
    run_req(0, 2'b01, 26'h0000010, 26'h0, 0);
    chk("single_word", 64'(d0[0]), 64'(32'h44332211));

    // Tie again, now with last=m0: m1 goes first.
    run_req(0, 2'b11, 26'h0000300, 26'h1000008, 0);

    // Chip-select decode on cs2.
    repeat (8) tick();
    run_req(0, 2'b10, 26'h0, 26'h2000004, 0);

    // Address near the top of the 24-bit space; flash wraps, no carry into CS.
    run_req(0, 2'b01, 26'h0FFFFFE, 26'h0, 0);

    // Reset at cycle 40 of a DIV=1 read.
    repeat (10) tick();
    t0 = cyc;
    a0[0] = 26'h0000040;
    v0[0] = 1'b1;
    for (int n = 0; n < 100 && cyc != t0 + 40; n++) tick();
    rst = 1'b1;
    v0[0] = 1'b0;
    tick();
    chk("midrst_cs_n", 64'(csn[0]), 64'(4'hF));
    chk("midrst_sck", 64'(sck[0]), 64'(0));
    chk("midrst_rdata", 64'(d0[0]), 64'(0));
    rst = 1'b0;
    free_at = '{0, 0};
    exp_last = '{1'b1, 1'b1};
    repeat (300) tick();
    run_req(0, 2'b11, 26'h1ABCDEF, 26'h3000030, 0);

    // Valid dropped at cycle 10: the read still completes, then nothing more.
    repeat (10) tick();
    run_req(0, 2'b01, 26'h0000020, 26'h0, 10);
    txn_before = fl_txn[0];
    repeat (300) tick();
    chk("idle_no_cs", 64'(fl_txn[0]), 64'(txn_before));

    // DIV=3, DESELECT=2: back-to-back m0 reads, then a tie.
    run_req(1, 2'b01, 26'h0000010, 26'h0, 0);
    chk("div3_word", 64'(d0[1]), 64'(32'h44332211));
    run_req(1, 2'b01, 26'h3000040, 26'h0, 0);
    run_req(1, 2'b11, 26'h1000001, 26'h2000002, 0);

    repeat (20) tick();
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
